// File: rtl/quiz_pkg.sv
// Shared definitions for the quiz sequencer: state codes, question-word
// field positions, prime-index limits and bus widths.
package quiz_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_WAIT   = 3'd2,
    S_ANSWER = 3'd3,
    S_JUDGE  = 3'd4,
    S_RESULT = 3'd5,
    S_DONE   = 3'd6
  } state_e;

  localparam int unsigned Q_HI = 23;
  localparam int unsigned Q_LO = 12;
  localparam int unsigned A_HI = 11;
  localparam int unsigned A_LO = 0;

  localparam int unsigned QWORD_W = 24;
  localparam int unsigned FIELD_W = 12;
  localparam int unsigned IDX_W   = 4;
  localparam int unsigned NUM_W   = 4;
  localparam int unsigned ECNT_W  = 2;
  localparam int unsigned SCORE_W = 5;
  localparam int unsigned STATE_W = 3;
  localparam int unsigned QCNT_W  = 5;
  localparam int unsigned CNT_W   = 16;
  localparam int unsigned TIMER_W = 16;

  localparam logic [IDX_W-1:0] IDX_BLANK = 4'd0;
  localparam logic [IDX_W-1:0] IDX_MAX   = 4'd9;

  // A key names a prime only in 1..9; blank and 10..15 are not answers.
  function automatic logic idx_valid(input logic [IDX_W-1:0] idx);
    return (idx != IDX_BLANK) && (idx <= IDX_MAX);
  endfunction

endpackage

// File: rtl/quiz_seq_ctrl_if.sv
// Front-end / ROM / display signals of the quiz sequencer, bundled.
interface quiz_seq_ctrl_if;
  import quiz_pkg::*;

  logic                 OK;
  logic                 KEY_VALID;
  logic [IDX_W-1:0]     KEY_IDX;
  logic                 SUBMIT;
  logic                 DB_REQ;
  logic [NUM_W-1:0]     NUM_OUT;
  logic [QWORD_W-1:0]   QUESTION;
  logic [FIELD_W-1:0]   Q_DIGITS;
  logic [FIELD_W-1:0]   ENTRY;
  logic [ECNT_W-1:0]    ENTRY_CNT;
  logic                 CORRECT;
  logic                 WRONG;
  logic [SCORE_W-1:0]   SCORE;
  logic                 DONE;
  logic [STATE_W-1:0]   STATE;

  modport master (
    input  OK, KEY_VALID, KEY_IDX, SUBMIT, QUESTION,
    output DB_REQ, NUM_OUT, Q_DIGITS, ENTRY, ENTRY_CNT,
           CORRECT, WRONG, SCORE, DONE, STATE
  );

  modport slave (
    output OK, KEY_VALID, KEY_IDX, SUBMIT, QUESTION,
    input  DB_REQ, NUM_OUT, Q_DIGITS, ENTRY, ENTRY_CNT,
           CORRECT, WRONG, SCORE, DONE, STATE
  );

endinterface

// File: rtl/quiz_timer.sv
// Loadable down-counter; saturates at zero and flags expiry while enabled.
module quiz_timer #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic         expired_c
);

  logic [W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (en && (count_q != '0)) begin
      count_d = count_q - W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expired_c = en && (count_q == '0);

endmodule

// File: rtl/quiz_seq_ctrl.sv
// Question sequencer: fetches each ROM word, collects up to three prime-index
// entries inside the answer window, judges them and keeps the session score.
module quiz_seq_ctrl
  import quiz_pkg::*;
#(
  parameter int unsigned NUM_Q      = 9,
  parameter int unsigned DB_LAT     = 1,
  parameter int unsigned TIME_LIMIT = 1000,
  parameter int unsigned RESULT_CYC = 8
) (
  input  logic           CLK,
  input  logic           RST,
  quiz_seq_ctrl_if.master bus
);

  localparam logic [CNT_W-1:0]   LAT_LAST = CNT_W'(DB_LAT - 1);
  localparam logic [CNT_W-1:0]   RES_LAST = CNT_W'(RESULT_CYC - 1);
  localparam logic [TIMER_W-1:0] T_LOAD   = TIMER_W'(TIME_LIMIT - 1);
  localparam logic [QCNT_W-1:0]  Q_END    = QCNT_W'(NUM_Q);

  state_e               state_q, state_d;
  logic [QCNT_W-1:0]    qcnt_q, qcnt_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [FIELD_W-1:0]   ans_q, ans_d;
  logic                 timed_out_q, timed_out_d;
  logic                 db_req_q, db_req_d;
  logic [NUM_W-1:0]     num_out_q, num_out_d;
  logic [FIELD_W-1:0]   q_digits_q, q_digits_d;
  logic [FIELD_W-1:0]   entry_q, entry_d;
  logic [ECNT_W-1:0]    entry_cnt_q, entry_cnt_d;
  logic                 correct_q, correct_d;
  logic                 wrong_q, wrong_d;
  logic [SCORE_W-1:0]   score_q, score_d;
  logic                 done_q, done_d;

  logic                 timer_load_c;
  logic                 timer_en_c;
  logic                 expired_c;
  logic [QCNT_W-1:0]    qcnt_inc_c;

  assign timer_en_c = (state_q == S_ANSWER);
  assign qcnt_inc_c = qcnt_q + QCNT_W'(1);

  quiz_timer #(.W(TIMER_W)) u_timer (
    .clk       (CLK),
    .rst       (RST),
    .load      (timer_load_c),
    .load_val  (T_LOAD),
    .en        (timer_en_c),
    .expired_c (expired_c)
  );

  always_comb begin
    state_d      = state_q;
    qcnt_d       = qcnt_q;
    cnt_d        = cnt_q;
    ans_d        = ans_q;
    timed_out_d  = timed_out_q;
    db_req_d     = 1'b0;
    num_out_d    = num_out_q;
    q_digits_d   = q_digits_q;
    entry_d      = entry_q;
    entry_cnt_d  = entry_cnt_q;
    correct_d    = 1'b0;
    wrong_d      = 1'b0;
    score_d      = score_q;
    done_d       = done_q;
    timer_load_c = 1'b0;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (bus.OK) begin
          state_d   = S_FETCH;
          score_d   = '0;
          qcnt_d    = '0;
          db_req_d  = 1'b1;
          num_out_d = '0;
          done_d    = 1'b0;
        end
      end
      S_FETCH: begin
        state_d = S_WAIT;
        cnt_d   = '0;
      end
      S_WAIT: begin
        // ROM data is valid only on the last latency cycle.
        if (cnt_q == LAT_LAST) begin
          q_digits_d   = bus.QUESTION[Q_HI:Q_LO];
          ans_d        = bus.QUESTION[A_HI:A_LO];
          entry_d      = '0;
          entry_cnt_d  = '0;
          timer_load_c = 1'b1;
          state_d      = S_ANSWER;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_ANSWER: begin
        if (bus.KEY_VALID && idx_valid(bus.KEY_IDX) && (entry_cnt_q != 2'd3)) begin
          case (entry_cnt_q)
            2'd0:    entry_d[11:8] = bus.KEY_IDX;
            2'd1:    entry_d[7:4]  = bus.KEY_IDX;
            default: entry_d[3:0]  = bus.KEY_IDX;
          endcase
          entry_cnt_d = entry_cnt_q + ECNT_W'(1);
        end
        // SUBMIT beats a coincident expiry.
        if (bus.SUBMIT) begin
          timed_out_d = 1'b0;
          state_d     = S_JUDGE;
        end else if (expired_c) begin
          timed_out_d = 1'b1;
          state_d     = S_JUDGE;
        end
      end
      S_JUDGE: begin
        if (!timed_out_q && (entry_q == ans_q)) begin
          correct_d = 1'b1;
          score_d   = score_q + SCORE_W'(1);
        end else begin
          wrong_d = 1'b1;
        end
        cnt_d   = '0;
        state_d = S_RESULT;
      end
      S_RESULT: begin
        if (cnt_q == RES_LAST) begin
          qcnt_d = qcnt_inc_c;
          if (qcnt_inc_c == Q_END) begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end else begin
            state_d   = S_FETCH;
            db_req_d  = 1'b1;
            num_out_d = NUM_W'(qcnt_inc_c);
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= S_IDLE;
      qcnt_q      <= '0;
      cnt_q       <= '0;
      ans_q       <= '0;
      timed_out_q <= 1'b0;
      db_req_q    <= 1'b0;
      num_out_q   <= '0;
      q_digits_q  <= '0;
      entry_q     <= '0;
      entry_cnt_q <= '0;
      correct_q   <= 1'b0;
      wrong_q     <= 1'b0;
      score_q     <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      qcnt_q      <= qcnt_d;
      cnt_q       <= cnt_d;
      ans_q       <= ans_d;
      timed_out_q <= timed_out_d;
      db_req_q    <= db_req_d;
      num_out_q   <= num_out_d;
      q_digits_q  <= q_digits_d;
      entry_q     <= entry_d;
      entry_cnt_q <= entry_cnt_d;
      correct_q   <= correct_d;
      wrong_q     <= wrong_d;
      score_q     <= score_d;
      done_q      <= done_d;
    end
  end

  assign bus.DB_REQ    = db_req_q;
  assign bus.NUM_OUT   = num_out_q;
  assign bus.Q_DIGITS  = q_digits_q;
  assign bus.ENTRY     = entry_q;
  assign bus.ENTRY_CNT = entry_cnt_q;
  assign bus.CORRECT   = correct_q;
  assign bus.WRONG     = wrong_q;
  assign bus.SCORE     = score_q;
  assign bus.DONE      = done_q;
  assign bus.STATE     = state_q;

endmodule

// File: doc/quiz_seq_ctrl.md
Name: quiz_seq_ctrl

Overview:
- Sequencer for the question ROM (24-bit question word: [23:12] three BCD question digits, [11:0] three 4-bit prime-index answer fields).
- Prime-index code: 0 = blank, 1..9 = primes 2,3,5,7,11,13,17,19,23.
- Walks a session of NUM_Q questions: issues the ROM index and read strobe, captures the word, collects up to three player factor entries under a time limit, judges them, keeps score.
- Sits between the keypad/button front end and the question ROM; drives the display fields.

Parameters:
- NUM_Q, 9, questions per session (1..16); ROM indices 0..NUM_Q-1.
- DB_LAT, 1, cycles from DB_REQ to QUESTION valid (1..4).
- TIME_LIMIT, 1000, answer window in cycles (< 2^16).
- RESULT_CYC, 8, cycles the verdict is held before the next fetch.

Ports:
- CLK  in  1  clock.
- RST  in  1  synchronous active-high reset.
- OK  in  1  start/restart pulse; honoured only in IDLE or DONE.
- KEY_VALID  in  1  one-cycle strobe; KEY_IDX is valid.
- KEY_IDX  in  4  entered prime index.
- SUBMIT  in  1  one-cycle strobe; finish entry.
- DB_REQ  out  1  one-cycle read strobe to the ROM.
- NUM_OUT  out  4  ROM index.
- QUESTION  in  24  ROM data.
- Q_DIGITS  out  12  captured question digits.
- ENTRY  out  12  entered indices; first entry in [11:8].
- ENTRY_CNT  out  2  number of entries.
- CORRECT  out  1  one-cycle verdict pulse.
- WRONG  out  1  one-cycle verdict pulse.
- SCORE  out  5  correct answers this session.
- DONE  out  1  high in DONE.
- STATE  out  3  state code for display/debug.

Behaviour:
- Reset values: all outputs 0; state IDLE; question counter 0.
- States: IDLE=0, FETCH=1, WAIT=2, ANSWER=3, JUDGE=4, RESULT=5, DONE=6.
- IDLE:
  - OK → FETCH; clear SCORE and question counter.
- FETCH:
  - DB_REQ=1 for exactly one cycle; NUM_OUT = question counter.
  - Next state WAIT.
- WAIT:
  - Count DB_LAT cycles.
  - On the last WAIT cycle, capture QUESTION: [23:12] to Q_DIGITS, [11:0] to the internal answer register.
  - Clear ENTRY and ENTRY_CNT; load timer with TIME_LIMIT-1; go to ANSWER.
- ANSWER:
  - KEY_VALID with KEY_IDX in 1..9 and ENTRY_CNT<3 stores KEY_IDX in the next field ([11:8], then [7:4], then [3:0]) and increments ENTRY_CNT.
  - Keys with KEY_IDX 0 or 10..15 are ignored. A fourth key is ignored.
  - Timer decrements every cycle.
  - SUBMIT → JUDGE. Timer reaching 0 → JUDGE with a forced wrong verdict.
  - KEY_VALID and SUBMIT in the same cycle: the key is stored first and is included in the judgement.
  - SUBMIT and timer expiry in the same cycle: SUBMIT wins (normal judgement).
  - Unentered fields stay 0, so an early SUBMIT compares against blank answer fields.
- JUDGE (1 cycle):
  - Correct iff not timed out and ENTRY == answer register (exact ordered 12-bit compare).
  - Correct: CORRECT pulses next cycle and SCORE increments. Otherwise WRONG pulses next cycle.
  - Next state RESULT.
- RESULT:
  - Hold ENTRY and Q_DIGITS for RESULT_CYC cycles.
  - Then increment the question counter. If it reaches NUM_Q → DONE; else → FETCH.
- DONE:
  - DONE=1; SCORE is held.
  - OK → FETCH with SCORE=0 and counter=0 (same clearing as from IDLE).
- OK is ignored in FETCH through RESULT.
- RST in any state, including mid-ANSWER or mid-WAIT, returns to reset values on the next edge with no further DB_REQ.
- SCORE cannot overflow because NUM_Q ≤ 16. The question counter does not wrap within a session.

Decomposition:
- Shared package quiz_pkg:
  - state encoding constants.
  - question-word field positions: Q_HI=23, Q_LO=12, A_HI=11, A_LO=0.
  - prime-index constants: IDX_BLANK=0, IDX_MAX=9.
- One sub-module: quiz_timer, a loadable down-counter with an expire flag, instantiated for the answer window.
- The RESULT hold counter is shared in the top-level.

Test Plan:
- Answer 42 correctly: NUM_Q=3; QUESTION=24'h042124. OK, keys 1,2,4, SUBMIT → Q_DIGITS=12'h042, ENTRY=12'h124, CORRECT pulse, SCORE=1, then DB_REQ with NUM_OUT=1 after RESULT_CYC.
- Wrong answer: QUESTION=24'h030123. Keys 1,2,4, SUBMIT → WRONG pulse, SCORE unchanged.
- Early submit and invalid keys: QUESTION=24'h006120. Keys 1,0,12,2, SUBMIT → invalid keys ignored, ENTRY=12'h120, ENTRY_CNT=2, CORRECT pulse.
- Timeout and simultaneous events:
  - No keys for TIME_LIMIT cycles → WRONG pulse.
  - Next question: KEY_VALID(4)+SUBMIT in the same cycle as expiry, answer 12'h224 with keys 2,2 entered earlier → CORRECT.
- Session end and restart: NUM_Q=3, three answers (2 correct) → DONE=1, SCORE=2; OK → SCORE=0, DB_REQ with NUM_OUT=0.
- Reset mid-operation: RST asserted in ANSWER after two keys → next cycle all outputs 0, STATE=IDLE; OK restarts from NUM_OUT=0.
